// File: rtl/class_result_serializer.sv
// Buffers classifier score bundles in a small FIFO and streams them out one word per beat,
// tagging each beat with its channel and reporting the argmax class on the last beat.
module class_result_serializer #(
    parameter int DATA_WIDHT  = 32,
    parameter int CHANNEL_OUT = 7,
    parameter int FIFO_DEPTH  = 4,
    parameter int ARGMAX_ONLY = 0,
    localparam int CW = (CHANNEL_OUT > 1) ? $clog2(CHANNEL_OUT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDHT*CHANNEL_OUT-1:0] Data_In,
    input  logic                              Valid_In,
    output logic                              In_Ready,
    output logic [DATA_WIDHT-1:0]             Data_Out,
    output logic                              Valid_Out,
    input  logic                              Ready_Out,
    output logic [CW-1:0]                     Ch_Idx,
    output logic                              Last_Out,
    output logic [CW-1:0]                     Class_Idx,
    output logic                              Overflow
);

    localparam int BW = DATA_WIDHT * CHANNEL_OUT;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] ONE_P   = 1;
    localparam logic [PW:0]   DEPTH_C = FIFO_DEPTH;
    localparam logic [PW:0]   ONE_C   = 1;
    localparam logic [CW-1:0] ONE_CH  = 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNEL_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_SCAN,
        S_HOLD
    } state_t;

    // Maps IEEE-754 bit patterns onto an unsigned scale with the same ordering.
    function automatic logic [DATA_WIDHT-1:0] f_key(input logic [DATA_WIDHT-1:0] x);
        return x[DATA_WIDHT-1] ? ~x : (x ^ {1'b1, {(DATA_WIDHT-1){1'b0}}});
    endfunction

    function automatic logic [DATA_WIDHT-1:0] f_word(input logic [BW-1:0] b, input logic [CW-1:0] ch);
        return b[int'(ch)*DATA_WIDHT +: DATA_WIDHT];
    endfunction

    logic [BW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [PW:0]           r_count;
    state_t                r_state;
    logic [DATA_WIDHT-1:0] r_run_max;
    logic [CW-1:0]         r_run_idx;
    logic                  r_run_vld;
    logic [DATA_WIDHT-1:0] r_scan_max;
    logic [CW-1:0]         r_scan_idx;
    logic [CW-1:0]         r_scan_ch;
    logic                  r_scan_vld;

    logic                  w_push;
    logic                  w_xfer;
    logic                  w_pop;
    logic [PW-1:0]         w_head_nxt;
    logic [BW-1:0]         w_head_bundle;
    logic [BW-1:0]         w_next_bundle;
    logic                  w_cur_wins;
    logic [DATA_WIDHT-1:0] w_scan_word;
    logic                  w_scan_wins;

    assign In_Ready      = (r_count != DEPTH_C);
    assign w_push        = Valid_In && In_Ready;
    assign w_xfer        = Valid_Out && Ready_Out;
    assign w_pop         = w_xfer && Last_Out;
    assign w_head_nxt    = r_head + ONE_P;
    assign w_head_bundle = r_mem[r_head];
    assign w_next_bundle = r_mem[w_head_nxt];

    // The word on the output competes with the running max, so the last beat's
    // Class_Idx already accounts for that word. In argmax-only mode r_run_vld stays 0.
    assign w_cur_wins = !r_run_vld || (f_key(Data_Out) > f_key(r_run_max));
    assign Class_Idx  = w_cur_wins ? Ch_Idx : r_run_idx;

    assign w_scan_word = f_word(w_head_bundle, r_scan_ch);
    assign w_scan_wins = !r_scan_vld || (f_key(w_scan_word) > f_key(r_scan_max));

    // NOTE: the bundle storage has no reset; r_count/r_head/r_tail alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_tail] <= Data_In;
        end
    end

    // NOTE: every register here uses <= so all reads see pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            Valid_Out  <= 1'b0;
            Last_Out   <= 1'b0;
            Data_Out   <= '0;
            Ch_Idx     <= '0;
            Overflow   <= 1'b0;
            r_run_max  <= '0;
            r_run_idx  <= '0;
            r_run_vld  <= 1'b0;
            r_scan_max <= '0;
            r_scan_idx <= '0;
            r_scan_ch  <= '0;
            r_scan_vld <= 1'b0;
        end else begin
            if (Valid_In && !In_Ready) begin
                Overflow <= 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + ONE_P;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_C;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE_C;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        if (ARGMAX_ONLY == 0) begin
                            r_state   <= S_SEND;
                            Valid_Out <= 1'b1;
                            Data_Out  <= f_word(w_head_bundle, '0);
                            Ch_Idx    <= '0;
                            Last_Out  <= 1'b0;
                            r_run_vld <= 1'b0;
                        end else begin
                            r_state    <= S_SCAN;
                            r_scan_ch  <= '0;
                            r_scan_vld <= 1'b0;
                        end
                    end
                end

                S_SEND: begin
                    if (w_xfer) begin
                        if (w_cur_wins) begin
                            r_run_max <= Data_Out;
                            r_run_idx <= Ch_Idx;
                        end
                        r_run_vld <= 1'b1;
                        if (Last_Out) begin
                            r_run_vld <= 1'b0;
                            // Head advances this edge, so the follow-on bundle is read one slot ahead.
                            if (r_count > ONE_C) begin
                                Data_Out <= f_word(w_next_bundle, '0);
                                Ch_Idx   <= '0;
                                Last_Out <= 1'b0;
                            end else begin
                                r_state   <= S_IDLE;
                                Valid_Out <= 1'b0;
                                Last_Out  <= 1'b0;
                            end
                        end else begin
                            Data_Out <= f_word(w_head_bundle, Ch_Idx + ONE_CH);
                            Ch_Idx   <= Ch_Idx + ONE_CH;
                            Last_Out <= ((Ch_Idx + ONE_CH) == LAST_CH);
                        end
                    end
                end

                S_SCAN: begin
                    if (w_scan_wins) begin
                        r_scan_max <= w_scan_word;
                        r_scan_idx <= r_scan_ch;
                    end
                    r_scan_vld <= 1'b1;
                    if (r_scan_ch == LAST_CH) begin
                        r_state   <= S_HOLD;
                        Valid_Out <= 1'b1;
                        Last_Out  <= 1'b1;
                        Data_Out  <= w_scan_wins ? w_scan_word : r_scan_max;
                        Ch_Idx    <= w_scan_wins ? r_scan_ch : r_scan_idx;
                    end else begin
                        r_scan_ch <= r_scan_ch + ONE_CH;
                    end
                end

                S_HOLD: begin
                    if (w_xfer) begin
                        Valid_Out <= 1'b0;
                        Last_Out  <= 1'b0;
                        if (r_count > ONE_C) begin
                            r_state    <= S_SCAN;
                            r_scan_ch  <= '0;
                            r_scan_vld <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_class_result_serializer.sv
// Self-checking bench: a serializing instance checked beat-by-beat against a queue model,
// and an argmax-only instance checked against hand-derived table values.
module tb_class_result_serializer;

    localparam int DW = 32;
    localparam int CO = 7;
    localparam int CW = 3;

    typedef logic [CO-1:0][DW-1:0] bundle_t;
    typedef struct packed {
        bundle_t       w;
        logic [CW-1:0] cls;
        logic [DW-1:0] mx;
    } vec_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] ch;
        logic          last;
        logic [CW-1:0] cls;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    bundle_t       data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out = 1'b0;

    logic          in_ready0, valid_out0, last_out0, overflow0;
    logic [DW-1:0] data_out0;
    logic [CW-1:0] ch_idx0, class_idx0;
    logic          in_ready1, valid_out1, last_out1, overflow1;
    logic [DW-1:0] data_out1;
    logic [CW-1:0] ch_idx1, class_idx1;

    class_result_serializer #(.DATA_WIDHT(DW), .CHANNEL_OUT(CO), .FIFO_DEPTH(4), .ARGMAX_ONLY(0)) dut0 (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in), .In_Ready(in_ready0),
        .Data_Out(data_out0), .Valid_Out(valid_out0), .Ready_Out(ready_out), .Ch_Idx(ch_idx0),
        .Last_Out(last_out0), .Class_Idx(class_idx0), .Overflow(overflow0)
    );

    class_result_serializer #(.DATA_WIDHT(DW), .CHANNEL_OUT(CO), .FIFO_DEPTH(4), .ARGMAX_ONLY(1)) dut1 (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in), .In_Ready(in_ready1),
        .Data_Out(data_out1), .Valid_Out(valid_out1), .Ready_Out(ready_out), .Ch_Idx(ch_idx1),
        .Last_Out(last_out1), .Class_Idx(class_idx1), .Overflow(overflow1)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    int    n_beats = 0;
    int    m_cnt = 0;
    bit    m_ovf = 1'b0;
    bit    mon_en = 1'b0;
    beat_t exp_q[$];
    beat_t mon_b;
    vec_t  tbl [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bundle_t b);
        data_in  = b;
        valid_in = 1'b1;
        step(1);
        valid_in = 1'b0;
    endtask

    // Float ordering by sign/magnitude: positives above negatives, +0 above -0, NaN by bit pattern.
    function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a > b;
        return a < b;
    endfunction

    function automatic int argmax(input bundle_t b);
        int best = 0;
        for (int i = 1; i < CO; i++) if (gt(b[i], b[best])) best = i;
        return best;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h3F80_0000;
            3: return 32'hBF80_0000;
            4: return 32'h7FC0_0000;
            5: return 32'h3F80_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        for (int i = 0; i < CO; i++) b[i] = rand_word();
        return b;
    endfunction

    function automatic vec_t mk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6,
                                input int cls, input logic [31:0] mx);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.w[4] = w4; v.w[5] = w5; v.w[6] = w6;
        v.cls  = CW'(cls);
        v.mx   = mx;
        return v;
    endfunction

    // Serializing-instance model: every valid output must equal the head of the expected-beat queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                check("in_ready", in_ready0, 32'(m_cnt != 4));
                check("overflow", overflow0, 32'(m_ovf));
                if (valid_out0) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 1, 0);
                    end else begin
                        check("beat_data", data_out0, exp_q[0].d);
                        check("beat_ch", 32'(ch_idx0), 32'(exp_q[0].ch));
                        check("beat_last", 32'(last_out0), 32'(exp_q[0].last));
                        if (exp_q[0].last) check("beat_class", 32'(class_idx0), 32'(exp_q[0].cls));
                    end
                end
                if (valid_in) begin
                    if (m_cnt != 4) begin
                        for (int k = 0; k < CO; k++) begin
                            exp_q.push_back('{d: data_in[k], ch: CW'(k), last: (k == CO - 1),
                                              cls: CW'(argmax(data_in))});
                        end
                        m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (valid_out0 && ready_out && exp_q.size() > 0) begin
                    mon_b = exp_q.pop_front();
                    n_beats++;
                    if (mon_b.last) m_cnt--;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        bundle_t     b;
        int          b0;
        int          n;
        bit          seen;
        logic [3:0]  pat;

        tbl[0] = mk(32'h3F800000, 32'h40200000, 32'hC0400000, 32'h3F000000, 0, 0, 0, 1, 32'h40200000);
        tbl[1] = mk(32'hBF800000, 32'hBF800000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000,
                    32'hC0000000, 3, 32'h00000000);
        tbl[2] = mk(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hBF800000, 32'hC1000000, 32'hC0800000,
                    32'hBF000000, 6, 32'hBF000000);
        tbl[3] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                    32'h3F800000, 0, 32'h3F800000);
        tbl[4] = mk(32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'hFFC00000, 0, 0, 32'h7FC00000,
                    2, 32'h7FC00000);

        // Reset state
        rst = 1'b1;
        mon_en = 1'b1;
        step(2);
        check("rst_valid0", valid_out0, 0);
        check("rst_last0", last_out0, 0);
        check("rst_data0", data_out0, 0);
        check("rst_ch0", 32'(ch_idx0), 0);
        check("rst_class0", 32'(class_idx0), 0);
        check("rst_ovf0", overflow0, 0);
        check("rst_rdy0", in_ready0, 1);
        check("rst_valid1", valid_out1, 0);
        check("rst_class1", 32'(class_idx1), 0);
        check("rst_rdy1", in_ready1, 1);
        rst = 1'b0;
        step(1);

        // Table vectors through both instances, first one also checks mode-0 latency
        ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].w);
            if (i == 0) begin
                check("lat0_early", valid_out0, 0);
                step(1);
                check("lat0_valid", valid_out0, 1);
                check("lat0_ch", 32'(ch_idx0), 0);
                check("lat0_data", data_out0, tbl[0].w[0]);
            end
            for (int k = 0; k < 20 && !(valid_out0 && last_out0); k++) step(1);
            check("tbl_last_seen", 32'(valid_out0 && last_out0), 1);
            check("tbl_class0", 32'(class_idx0), 32'(tbl[i].cls));
            for (int k = 0; k < 20 && !valid_out1; k++) step(1);
            check("tbl_m1_valid", valid_out1, 1);
            check("tbl_m1_data", data_out1, tbl[i].mx);
            check("tbl_m1_ch", 32'(ch_idx1), 32'(tbl[i].cls));
            check("tbl_m1_class", 32'(class_idx1), 32'(tbl[i].cls));
            check("tbl_m1_last", last_out1, 1);
            step(2);
        end

        // Backpressure pattern 1,0,0,1
        pat = 4'b1001;
        ready_out = 1'b0;
        push(rand_bundle());
        push(rand_bundle());
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
            ready_out = pat[c % 4];
            step(1);
        end
        check("t3_drained", exp_q.size(), 0);

        // FIFO full with Ready_Out held low
        ready_out = 1'b0;
        step(4);
        for (int i = 0; i < 5; i++) begin
            push(rand_bundle());
            if (i == 3) check("t4_full", in_ready0, 0);
        end
        check("t4_ovf0", overflow0, 1);
        check("t4_ovf1", overflow1, 1);
        check("t4_full1", in_ready1, 0);
        b0 = n_beats;
        ready_out = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) step(1);
        check("t4_beats", n_beats - b0, 28);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);

        // Back-to-back bundles must stream without a bubble
        ready_out = 1'b0;
        push(rand_bundle());
        push(rand_bundle());
        ready_out = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && valid_out0; k++) begin
            n++;
            step(1);
        end
        check("t5_run", n, 14);
        step(10);

        // Randomized traffic against the queue model
        for (int c = 0; c < 600; c++) begin
            valid_in  = ($urandom_range(0, 2) == 0);
            data_in   = rand_bundle();
            ready_out = ($urandom_range(0, 3) != 0);
            step(1);
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) step(1);
        check("rand_drained", exp_q.size(), 0);

        // Argmax-only latency and reset during scan
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        ready_out = 1'b1;
        push(tbl[0].w);
        step(7);
        check("t6_early", valid_out1, 0);
        step(1);
        check("t6_valid", valid_out1, 1);
        check("t6_data", data_out1, 32'h40200000);
        check("t6_ch", 32'(ch_idx1), 1);
        check("t6_class", 32'(class_idx1), 1);
        check("t6_last", last_out1, 1);
        step(3);
        push(tbl[0].w);
        step(3);
        rst = 1'b1;
        step(1);
        check("t6_rst_valid", valid_out1, 0);
        check("t6_rst_rdy", in_ready1, 1);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            seen |= valid_out1;
        end
        check("t6_discarded", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
